matrix_scan_driver: RTL
=======================

# matrix_scan_driver

Row-scanning driver for the 5×7 LED map display; sits directly downstream of the 7-bit map selector mux. It latches selected 7-bit row patterns into an internal frame buffer and multiplexes them onto the matrix one row at a time, with a blanking cycle between rows. It also generates the blink toggle that drives the mux's `sel` input, which alternates between map 0 and map 1.

## Interface
- `ROWS`, 5: matrix rows, 2..8.
- `COLS`, 7: columns per row, equal to the mux output width.
- `SCAN_DIV`, 1000: clock cycles each row is driven, ≥2.
- `BLINK_FRAMES`, 50: full frames per `sel_out` toggle, ≥1.

Ports:
- `clk`  in  1: single clock; all state on rising edge.
- `reset`  in  1: asynchronous, active-high.
- `enable`  in  1: display on/off.
- `wr_en`  in  1: write `map_in` into the buffer row `wr_row`.
- `wr_row`  in  3: buffer row index.
- `map_in`  in  COLS: row pattern from the mux `out`.
- `row_n`  out  ROWS: active-low one-hot row enable.
- `col`  out  COLS: active-high column drive.
- `sel_out`  out  1: blink select, feeds mux `sel`.
- `frame_tick`  out  1: one-cycle pulse per completed frame.

## Operation
- **Frame buffer:** ROWS×COLS registers, all cleared by `reset`.
  - With `wr_en`=1 and `wr_row`<ROWS, the buffer row `wr_row` is loaded with `map_in` at the edge.
  - With `wr_row`≥ROWS, the write is ignored.
  - Writes are accepted in every state.
- **FSM states:** IDLE, DRIVE, BLANK. `row_idx` runs 0..ROWS-1; `presc` runs 0..SCAN_DIV-1.
  - IDLE: `row_idx`=0, `presc`=0. If `enable`=1, go to DRIVE.
  - DRIVE: `presc` increments. At `presc`=SCAN_DIV-1: `presc`←0, `row_idx`←(`row_idx`+1) mod ROWS (ROWS-1 wraps to 0), go to BLANK.
  - BLANK: lasts one cycle, then return to DRIVE.
  - `enable`=0 sampled in any state: go to IDLE and clear `row_idx` and `presc`. This takes priority over all other transitions.
- **Outputs (Moore decode of registered state):**
  - DRIVE: `row_n`=~(1<<`row_idx`), `col`=buffer[`row_idx`].
  - IDLE or BLANK: `row_n`=all ones, `col`=0.
  - `frame_tick` = (state==BLANK && `row_idx`==0), i.e. the blank cycle that follows the last row.
- **Blink:**
  - `fcnt` (0..BLINK_FRAMES-1) increments on each `frame_tick` cycle.
  - On `frame_tick` with `fcnt`=BLINK_FRAMES-1: `fcnt`←0 and `sel_out` toggles.
  - `fcnt` and `sel_out` hold in IDLE; only `reset` clears them.
- **Reset values:** state IDLE, `row_idx`=0, `presc`=0, `fcnt`=0, buffer=0. Outputs: `row_n`=all ones, `col`=0, `sel_out`=0, `frame_tick`=0.

## Timing
- `enable` sampled high at edge k while in IDLE: from edge k, `row_n`=~1 and `col`=buffer[0].
- Each row is driven for exactly SCAN_DIV cycles, then blanked for 1 cycle. Row period is SCAN_DIV+1 cycles; frame period is ROWS·(SCAN_DIV+1).
- Write to the row currently displayed: `col` shows the new value in the cycle right after the write edge. There is no tearing within a cycle.
- `enable` falling: outputs dark in the cycle after the sampling edge. Re-enabling always restarts at row 0 with a full SCAN_DIV dwell.
- `reset` asserted mid-operation: all registers and outputs take their reset values immediately, without waiting for `clk`.
- `sel_out` period is 2·BLINK_FRAMES frames. The mux sees each toggle combinationally; the new map reaches `col` only through a later write.

## Structure
- Shared package `matrix_pkg` holds:
  - state encoding constants (IDLE=2'd0, DRIVE=2'd1, BLANK=2'd2);
  - default ROWS/COLS values shared with the mux and map storage.
- Sub-module `scan_prescaler`: a modulo-N counter with clear and terminal-count output. It is instantiated for `presc` and reusable for `fcnt`.
- Row decode, FSM and frame buffer stay in the top block.

## Test plan
Bench parameters: ROWS=5, COLS=7, SCAN_DIV=4, BLINK_FRAMES=2.
1. **Reset:** assert `reset` → `row_n`=11111, `col`=0000000, `sel_out`=0, `frame_tick`=0. With `enable`=1 after release, every row shows 0000000.
2. **Scan order:** write rows 0..4 = 1000001, 1100011, 0111110, 0011100, 0001000, then set `enable`=1.
   - Expect `row_n`=11110/`col`=1000001 for 4 cycles, then 1 dark cycle, then 11101/1100011 for 4 cycles, and so on through row 4.
   - Row 0 repeats at cycle 25.
3. **Frame and blink:** `frame_tick` pulses for one cycle every 25 cycles, on the blank after row 4. `sel_out` toggles on every 2nd tick, i.e. every 50 cycles.
4. **Live and invalid writes:**
   - Write 0101010 to row 2 while row 2 is driven: `col`=0101010 from the next cycle.
   - Writes with `wr_row`=5, 6 or 7 leave all buffer rows unchanged.
5. **Enable gating:** drop `enable` during the 2nd dwell cycle of row 3.
   - The next cycle is dark; `sel_out` and `fcnt` hold.
   - On re-enable, row 0 is driven for a full 4 cycles.
6. **Async reset mid-frame:** pulse `reset` between clock edges during row 1. Outputs go to reset values immediately, and the buffer reads all zeros afterwards.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the LED map display: scan FSM encoding and default geometry.
package matrix_pkg;

  localparam int unsigned ROWS_DEF   = 5;
  localparam int unsigned COLS_DEF   = 7;
  localparam int unsigned ROW_ADDR_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_e;

endpackage

// File: rtl/matrix_scan_driver_if.sv
// Buffer write port and matrix drive outputs of the row-scanning driver.
interface matrix_scan_driver_if
  import matrix_pkg::*;
#(
  parameter int unsigned ROWS = ROWS_DEF,
  parameter int unsigned COLS = COLS_DEF
) ();

  logic                  enable;
  logic                  wr_en;
  logic [ROW_ADDR_W-1:0] wr_row;
  logic [COLS-1:0]       map_in;
  logic [ROWS-1:0]       row_n;
  logic [COLS-1:0]       col;
  logic                  sel_out;
  logic                  frame_tick;

  modport master (
    output enable, wr_en, wr_row, map_in,
    input  row_n, col, sel_out, frame_tick
  );

  modport slave (
    input  enable, wr_en, wr_row, map_in,
    output row_n, col, sel_out, frame_tick
  );

endinterface

// File: rtl/scan_prescaler.sv
// Modulo-N up counter with synchronous clear and combinational terminal-count flag.
module scan_prescaler #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc_c
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0] r_cnt;

  assign o_tc_c = (r_cnt == CW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= o_tc_c ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/matrix_scan_driver.sv
// Row-scanning LED matrix driver: frame buffer, row/blank scan FSM and blink select.
// Outputs are registered from the next-state decode so they track the FSM state exactly.
module matrix_scan_driver
  import matrix_pkg::*;
#(
  parameter int unsigned ROWS         = ROWS_DEF,
  parameter int unsigned COLS         = COLS_DEF,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLINK_FRAMES = 50
) (
  input  logic                  clk,
  input  logic                  reset,
  matrix_scan_driver_if.slave   bus
);

  localparam int unsigned RW = $clog2(ROWS);

  scan_state_e     r_state;
  scan_state_e     w_state_nxt;
  logic [RW-1:0]   r_row_idx;
  logic [RW-1:0]   w_row_nxt;
  logic [COLS-1:0] r_buf [ROWS];

  logic [ROWS-1:0] r_row_n;
  logic [COLS-1:0] r_col;
  logic            r_sel;
  logic            r_frame_tick;

  logic [ROWS-1:0] w_row_n_nxt;
  logic [COLS-1:0] w_col_nxt;
  logic            w_tick_nxt;
  logic            w_wr_hit;
  logic            w_presc_tc;
  logic            w_fcnt_tc;

  assign w_wr_hit = bus.wr_en && (32'(bus.wr_row) < ROWS);

  scan_prescaler #(.N(SCAN_DIV)) u_presc (
    .clk    (clk),
    .rst    (reset),
    .i_clr  (!bus.enable),
    .i_inc  (r_state == ST_DRIVE),
    .o_tc_c (w_presc_tc)
  );

  scan_prescaler #(.N(BLINK_FRAMES)) u_fcnt (
    .clk    (clk),
    .rst    (reset),
    .i_clr  (1'b0),
    .i_inc  (r_frame_tick),
    .o_tc_c (w_fcnt_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf <= '{default: '0};
    end else if (w_wr_hit) begin
      r_buf[bus.wr_row[RW-1:0]] <= bus.map_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_row_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_row_idx <= w_row_nxt;
    end
  end

  // Next state plus output decode of that state; a same-edge write to the next row bypasses the buffer.
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row_idx;
    w_row_n_nxt = '1;
    w_col_nxt   = '0;
    w_tick_nxt  = 1'b0;

    if (!bus.enable) begin
      w_state_nxt = ST_IDLE;
      w_row_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_DRIVE;
        ST_DRIVE: begin
          if (w_presc_tc) begin
            w_state_nxt = ST_BLANK;
            w_row_nxt   = (r_row_idx == RW'(ROWS - 1)) ? '0 : r_row_idx + RW'(1);
          end
        end
        ST_BLANK: w_state_nxt = ST_DRIVE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end

    if (w_state_nxt == ST_DRIVE) begin
      w_row_n_nxt = ~(ROWS'(1) << w_row_nxt);
      w_col_nxt   = (w_wr_hit && (32'(bus.wr_row) == 32'(w_row_nxt))) ? bus.map_in
                                                                       : r_buf[w_row_nxt];
    end
    w_tick_nxt = (w_state_nxt == ST_BLANK) && (w_row_nxt == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row_n      <= '1;
      r_col        <= '0;
      r_frame_tick <= 1'b0;
      r_sel        <= 1'b0;
    end else begin
      r_row_n      <= w_row_n_nxt;
      r_col        <= w_col_nxt;
      r_frame_tick <= w_tick_nxt;
      if (r_frame_tick && w_fcnt_tc) begin
        r_sel <= ~r_sel;
      end
    end
  end

  assign bus.row_n      = r_row_n;
  assign bus.col        = r_col;
  assign bus.sel_out    = r_sel;
  assign bus.frame_tick = r_frame_tick;

endmodule
